// File: rtl/dual_rail_ingress_fifo.sv
// ---------------------------------------------------------------------------
// dual_rail_ingress_fifo
//
// Clocked ingress bridge from a WIDTH-bit dual-rail, 4-phase return-to-zero
// channel into a synchronous valid/ready stream. Completion is detected on
// the sampled dual-rail word. A complete word is decoded from its true rails
// and pushed into a DEPTH-entry show-ahead FIFO. The 4-phase acknowledge is
// then driven back to the asynchronous stage chain.
//
// Parameters:
//   WIDTH  data bits per word (channel carries 2*WIDTH rails)
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      dual-rail word; bit i = {true data_in[2i+1], false data_in[2i]}
//   ack          registered 4-phase acknowledge to the sender
//   out_data     FIFO head word (valid while out_valid)
//   out_valid    FIFO not empty
//   out_ready    consumer takes the head word this cycle
//   level        number of stored words
//   err_illegal  sticky: some bit was seen with both rails high
//
// Build option:
//   DR_INGRESS_SYNC_EN  when defined, each rail passes through a two-flop
//                       synchroniser (reset to 0) before decode. Use it when
//                       the sender is asynchronous to clk. Every latency
//                       grows by 2 cycles. When undefined, data_in is decoded
//                       combinationally, so the sender must be synchronous
//                       to clk.
//
// Handshake FSM:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ack=0, waiting for a complete word (or an illegal code)
//   ST_ACK   | ack=1, word pushed, waiting for the sender to return to spacer
//   ST_DRAIN | ack=1, illegal code seen, waiting for spacer; nothing pushed
// ---------------------------------------------------------------------------
module dual_rail_ingress_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*WIDTH-1:0]       data_in,
  output logic                     ack,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Channel sampling
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] s;

`ifdef DR_INGRESS_SYNC_EN
  logic [2*WIDTH-1:0] sync1_q;
  logic [2*WIDTH-1:0] sync2_q;

  // The 4-phase protocol keeps rails monotonic within a phase. A partially
  // synchronised word therefore only looks incomplete, and is never
  // mistaken for a different complete word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = data_in;
`endif

  // -------------------------------------------------------------------------
  // Dual-rail decode
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] bit_complete;
  logic [WIDTH-1:0] bit_illegal;
  logic [WIDTH-1:0] word_data;
  logic             word_complete;
  logic             word_illegal;
  logic             word_spacer;

  always_comb begin
    bit_complete = '0;
    bit_illegal  = '0;
    word_data    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_complete[i] = s[2*i+1] ^ s[2*i];
      bit_illegal[i]  = s[2*i+1] & s[2*i];
      word_data[i]    = s[2*i+1];
    end
  end

  assign word_complete = &bit_complete;
  assign word_illegal  = |bit_illegal;
  assign word_spacer   = ~|s;

  // -------------------------------------------------------------------------
  // FIFO status
  // -------------------------------------------------------------------------
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full;
  logic          push;
  logic          pop;

  // The full check uses the registered level only. A pop in the same cycle
  // does not open a slot for a push until the next cycle. This keeps the
  // out_ready path out of the push and ack decision.
  assign full      = (level_q == LEVEL_FULL);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   ack_q;
  logic   ack_d;
  logic   err_q;
  logic   set_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_q | set_err;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (word_illegal) begin
          state_d = ST_DRAIN;
        end else if (word_complete && !full) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK, ST_DRAIN: begin
        if (word_spacer) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  // ack is taken from a dedicated flop loaded from the next state. The
  // sender therefore never sees a decode glitch.
  always_comb begin
    push    = 1'b0;
    set_err = 1'b0;
    ack_d   = (state_d == ST_ACK) || (state_d == ST_DRAIN);
    if (state_q == ST_IDLE) begin
      if (word_illegal) begin
        set_err = 1'b1;
      end else if (word_complete && !full) begin
        push = 1'b1;
      end
    end
  end

  assign ack         = ack_q;
  assign err_illegal = err_q;

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;

  // The storage has no reset. out_data is don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_data;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // The pointers are AW bits wide and DEPTH is a power of two. Wrap modulo
  // DEPTH therefore falls out of natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  assign out_data = mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: tb/tb_dual_rail_ingress_fifo.sv
// Directed self-checking bench for dual_rail_ingress_fifo (WIDTH=4, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are read at that point.
module tb_dual_rail_ingress_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
`ifdef DR_INGRESS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         out_ready = 1'b0;
  logic         ack;
  logic [3:0]   out_data;
  logic         out_valid;
  logic [2:0]   level;
  logic         err_illegal;

  int checks = 0;
  int errors = 0;

  dual_rail_ingress_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .ack         (ack),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic want, output bit ok);
    ok = (ack === want);
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      ok = (ack === want);
    end
  endtask

  task automatic send_word(input logic [3:0] v, output bit ok);
    bit ok1, ok2;
    data_in = enc(v);
    wait_ack(1'b1, ok1);
    data_in = 8'h00;
    wait_ack(1'b0, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_illegal); end
    step(); step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL pop_empty_level: got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_empty_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    data_in = 8'h99;
    repeat (LAT - 1) step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_early: got %b want 0", ack); end
    step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL single_ack_rise: got %b want 1", ack); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL single_data: got %h want a", out_data); end
    data_in = 8'h00;
    repeat (LAT - 1) step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL single_ack_hold: got %b want 1", ack); end
    step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL single_ack_fall: got %b want 0", ack); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_fill();
    bit ok;
    for (int k = 1; k <= 4; k++) begin
      send_word(4'(k), ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_handshake_%0d: timed out, want ack cycle", k); end
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level4: got %0d want 4", level); end
    data_in = enc(4'd5);
    repeat (LAT + 3) step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL fill_full_ack: got %b want 0", ack); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_full_level: got %0d want 4", level); end
    checks++; if (out_data !== 4'd1) begin errors++; $display("FAIL fill_head: got %h want 1", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL fill_after_pop_level: got %0d want 3", level); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL fill_after_pop_ack: got %b want 0", ack); end
    checks++; if (out_data !== 4'd2) begin errors++; $display("FAIL fill_after_pop_head: got %h want 2", out_data); end
    step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL fill_5th_ack: got %b want 1", ack); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_5th_level: got %0d want 4", level); end
    data_in = 8'h00;
    wait_ack(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_5th_release: ack stuck high, want 0"); end
    for (int k = 2; k <= 5; k++) begin
      checks++; if (out_data !== 4'(k)) begin errors++; $display("FAIL fill_drain_%0d: got %h want %h", k, out_data, 4'(k)); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL fill_drained_level: got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_drained_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_partial();
    bit ok;
    data_in = 8'h15;
    repeat (10) step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL partial_ack: got %b want 0", ack); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL partial_level: got %0d want 0", level); end
    data_in = 8'h55;
    repeat (LAT) step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL partial_done_ack: got %b want 1", ack); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL partial_done_level: got %0d want 1", level); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL partial_done_data: got %h want 0", out_data); end
    data_in = 8'h00;
    wait_ack(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_release: ack stuck high, want 0"); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    bit ok;
    data_in = 8'h03;
    repeat (LAT) step();
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err_illegal); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL illegal_ack: got %b want 1", ack); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL illegal_level: got %0d want 0", level); end
    data_in = 8'h00;
    repeat (LAT) step();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL illegal_ack_fall: got %b want 0", ack); end
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", err_illegal); end
    send_word(4'd6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL illegal_next_handshake: timed out, want ack cycle"); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL illegal_next_level: got %0d want 1", level); end
    checks++; if (out_data !== 4'd6) begin errors++; $display("FAIL illegal_next_data: got %h want 6", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] q[$];
    logic [3:0] v;
    logic [3:0] exp_v;
    send_word(4'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_pre0: timed out, want ack cycle"); end
    send_word(4'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_pre1: timed out, want ack cycle"); end
    q.push_back(4'd7);
    q.push_back(4'd8);
    for (int k = 0; k < 12; k++) begin
      v = 4'(k * 5 + 3);
      data_in = enc(v);
      repeat (LAT - 1) step();
      out_ready = 1'b1;
      exp_v = q.pop_front();
      checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_head_%0d: got %h want %h", k, out_data, exp_v); end
      q.push_back(v);
      step();
      out_ready = 1'b0;
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_%0d: got %b want 1", k, ack); end
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level_%0d: got %0d want 2", k, level); end
      data_in = 8'h00;
      wait_ack(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_release_%0d: ack stuck high, want 0", k); end
    end
    for (int k = 0; k < 2; k++) begin
      exp_v = q.pop_front();
      checks++; if (out_data !== exp_v) begin errors++; $display("FAIL b2b_tail_%0d: got %h want %h", k, out_data, exp_v); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_final_level: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_word(4'd1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_pre0: timed out, want ack cycle"); end
    send_word(4'd2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_pre1: timed out, want ack cycle"); end
    data_in = enc(4'd3);
    repeat (LAT) step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rmid_ack: got %b want 1", ack); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_level: got %0d want 3", level); end
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL rmid_err_pre: got %b want 1", err_illegal); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rmid_rst_ack: got %b want 0", ack); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_rst_level: got %0d want 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_rst_valid: got %b want 0", out_valid); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL rmid_rst_err: got %b want 0", err_illegal); end
    step(); step();
    rst_n = 1'b1;
    repeat (LAT) step();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rmid_exit_ack: got %b want 1", ack); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL rmid_exit_level: got %0d want 1", level); end
    checks++; if (out_data !== 4'd3) begin errors++; $display("FAIL rmid_exit_data: got %h want 3", out_data); end
    data_in = 8'h00;
    wait_ack(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_exit_release: ack stuck high, want 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_partial();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/dual_rail_ingress_fifo.md
# dual_rail_ingress_fifo

Clocked ingress bridge from a WIDTH-bit dual-rail, 4-phase return-to-zero channel into a synchronous valid/ready stream. It detects completion on the dual-rail word, decodes it, stores it in a DEPTH-entry FIFO, and drives the 4-phase `ack` back to the asynchronous stage chain. It sits at the boundary where the asynchronous pipeline of dual-rail buffer stages hands data to clocked logic. It generalises the fixed 2-bit asynchronous buffer stage to any width, adds buffering depth, and adds illegal-code detection.

## Interface
- `WIDTH`, 4: data bits per word; the channel has 2*WIDTH rails.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data_in` input 2*WIDTH: dual-rail word; bit i has true rail `data_in[2i+1]` and false rail `data_in[2i]`.
- `ack` output 1: 4-phase acknowledge to the sender.
- `out_data` output WIDTH: FIFO head word (show-ahead).
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: consumer accepts the head word this cycle.
- `level` output $clog2(DEPTH)+1: number of stored words.
- `err_illegal` output 1: sticky flag; a bit was seen with both rails high.

## Operation
- `s` is the sampled channel value: `data_in` through the optional synchroniser (see Configuration), otherwise `data_in` directly.
- Per-bit decode of `s`:
  - complete = exactly one rail high.
  - illegal = both rails high.
  - spacer = both rails low.
- The word is complete when all bits are complete. The word is spacer when all rails are low. The word is illegal when any bit is illegal.
- State machine, 3 states, reset to IDLE:
  - IDLE, `ack`=0:
    - If any bit is illegal: set `err_illegal`, no push, go to DRAIN.
    - Else if the word is complete and `level`<DEPTH: push the decoded word (true rails), go to ACK.
    - Else, for a complete word when full or a partial word: stay in IDLE.
  - ACK, `ack`=1: on a spacer word, go to IDLE. Illegal codes seen in ACK are ignored.
  - DRAIN, `ack`=1: on a spacer word, go to IDLE. `err_illegal` stays set until reset.
- `ack` is a registered output: `ack` = 1 exactly in ACK or DRAIN.
- FIFO behaviour:
  - Push only as above. Pop when `out_valid && out_ready`.
  - Pointers wrap modulo DEPTH.
  - `level` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - The full check uses the registered `level`. A pop in the same cycle does not permit a push into a full FIFO; the push waits one cycle.
  - Popping when empty has no effect.
- Reset, mid-handshake included:
  - State = IDLE, `ack`=0, pointers=0, `level`=0, `out_valid`=0, `err_illegal`=0, synchroniser flops=0.
  - `out_data` is don't-care while `out_valid`=0.
  - After reset the sender must return to spacer. A complete word still present at reset exit is accepted as a new word.

## Timing
- A complete `s` in IDLE while not full gives `ack`=1 and the push on the same rising edge.
- `out_valid` and `level` update on that same edge.
- A spacer `s` in ACK/DRAIN gives `ack`=0 on the next edge.
- End-to-end latency, from `data_in` becoming complete to `ack` rising:
  - 1 cycle without the synchroniser.
  - 3 cycles with it.
- Spacer to `ack` fall: same latencies as ack rise.
- Minimum handshake period is 2 cycles without the synchroniser and 6 with it.
- Back-pressure: while full, `ack` stays 0. It rises on the edge after the first pop.

## Configuration
- `DR_INGRESS_SYNC_EN` defined:
  - `s` is `data_in` passed through a two-flop synchroniser per rail, reset to 0.
  - This is required when the sender is asynchronous to `clk`. Rail monotonicity in the 4-phase protocol keeps partial words harmless.
- `DR_INGRESS_SYNC_EN` undefined:
  - `s` = `data_in` combinationally.
  - The sender must be synchronous to `clk`.
  - All latencies drop by 2 cycles.

## Test plan
Bench uses WIDTH=4, DEPTH=4; latencies are stated without the synchroniser, add 2 cycles with it.
- Single word: `data_in`=0x99 (value 0xA), `out_ready`=0 → `ack`=1 after 1 cycle, `level`=1, `out_valid`=1, `out_data`=0xA. Then `data_in`=0x00 → `ack`=0 after 1 cycle.
- Fill: 5 words 1,2,3,4,5 with `out_ready`=0 → first 4 acked, `level`=4, 5th held with `ack`=0. Pulse `out_ready` for 1 cycle → head 1 leaves, `level`=3, then 5 is acked and `level`=4.
- Partial word: rails for bits 0–2 only, bit 3 spacer, held 10 cycles → `ack` stays 0 and `level`=0. Setting bit 3's false rail → word 0x0 pushed, `ack`=1.
- Illegal: `data_in`=0x03 → `err_illegal`=1, `ack`=1, `level` unchanged. Spacer → `ack`=0 while `err_illegal` stays 1. A following legal word is accepted normally.
- Simultaneous push and pop at `level`=2 with `out_ready`=1 → `level` stays 2 and read order is preserved across pointer wrap over 12 words.
- Reset asserted while in ACK with `level`=3 → immediately `ack`=0, `level`=0, `out_valid`=0, `err_illegal`=0.
